// File: rtl/flip_pkg.sv
// Shared types and helpers for the Flip-N-Write encoder.
// Contents: FSM state enum, popcount over a fixed-width vector, and the
// width helper for the total write-cost accumulator.
package flip_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // Widest component popcount supports; narrower words are zero-extended.
    localparam int unsigned POP_MAX_W = 256;

    // Number of set bits in v.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

    // Width of the block cost: the worst case is M*(N/2) changed bits.
    function automatic int unsigned cost_width(input int unsigned n, input int unsigned m);
        return $clog2(m * (n / 2) + 1);
    endfunction

endpackage

// File: rtl/flip_decide_word.sv
// Combinational Flip-N-Write decision for one N-bit component.
// Ports:
//   new_word - incoming component value
//   old_word - value currently stored downstream (raw, as held in the register)
//   enc      - value to store (inverted when flip is set)
//   flip     - store inverted; set only when strictly more than N/2 bits differ
//   cost     - number of stored bits that change for the chosen encoding
module flip_decide_word
    import flip_pkg::*;
#(
    parameter  int unsigned N  = 16,
    localparam int unsigned PW = $clog2(N + 1)
) (
    input  logic [N-1:0]  new_word,
    input  logic [N-1:0]  old_word,
    output logic [N-1:0]  enc,
    output logic          flip,
    output logic [PW-1:0] cost
);

    logic [PW-1:0] diff;

    // A tie (exactly N/2 differing bits) keeps the plain value.
    always_comb begin
        diff = PW'(popcount(POP_MAX_W'(new_word ^ old_word)));
        flip = (diff > PW'(N / 2));
        enc  = flip ? ~new_word : new_word;
        cost = flip ? (PW'(N) - diff) : diff;
    end

endmodule

// File: rtl/flip_encode_block.sv
// Flip-N-Write block encoder feeding the downstream register block.
// Snapshots a block of M components plus the current register contents,
// then encodes one component per cycle and hands the result downstream.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   in_valid   - upstream block available
//   in_ready   - encoder idle and able to accept a block
//   in_data    - new block, component i at index i
//   stored_q   - current downstream register contents
//   out_valid  - encoded block available
//   out_ready  - downstream accepts the block
//   out_data   - encoded block (only meaningful while out_valid)
//   out_flip   - bit i set when component i is stored inverted
//   out_cost   - total stored bits changed by the write
module flip_encode_block
    import flip_pkg::*;
#(
    parameter  int unsigned N  = 16,
    parameter  int unsigned M  = 16,
    localparam int unsigned CW = cost_width(N, M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data [M],
    input  logic [N-1:0]  stored_q [M],
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data [M],
    output logic [M-1:0]  out_flip,
    output logic [CW-1:0] out_cost
);

    localparam int unsigned PW = $clog2(N + 1);
    localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    state_t        state;
    state_t        state_n;
    logic          accept_c;
    logic [IW-1:0] idx;
    logic [N-1:0]  new_buf [M];
    logic [N-1:0]  old_buf [M];
    logic [N-1:0]  enc;
    logic          flip;
    logic [PW-1:0] cost;

    // Single shared decision unit, steered by idx.
    flip_decide_word #(.N(N)) u_decide (
        .new_word (new_buf[idx]),
        .old_word (old_buf[idx]),
        .enc      (enc),
        .flip     (flip),
        .cost     (cost)
    );

    // State register; handshake outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_n  = state;
        accept_c = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_n  = SCAN;
                end
            end
            SCAN: begin
                if (idx == LAST_IDX) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Snapshot buffers, per-component scan and cost accumulation.
    // out_cost doubles as the accumulator and is cleared on every accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            out_flip <= '0;
            out_cost <= '0;
            for (int unsigned i = 0; i < M; i++) begin
                new_buf[i]  <= '0;
                old_buf[i]  <= '0;
                out_data[i] <= '0;
            end
        end else begin
            if (accept_c) begin
                idx      <= '0;
                out_cost <= '0;
                for (int unsigned i = 0; i < M; i++) begin
                    new_buf[i] <= in_data[i];
                    old_buf[i] <= stored_q[i];
                end
            end
            if (state == SCAN) begin
                out_data[idx] <= enc;
                out_flip[idx] <= flip;
                out_cost      <= out_cost + CW'(cost);
                idx           <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_flip_encode_block.sv
// Self-checking bench for flip_encode_block (N=16, M=4).
module tb_flip_encode_block;

    localparam int unsigned N  = 16;
    localparam int unsigned M  = 4;
    localparam int unsigned CW = 6;

    typedef logic [M-1:0][N-1:0] blk_t;
    typedef struct packed {
        blk_t          data;
        logic [M-1:0]  flip;
        logic [CW-1:0] cost;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_data [M];
    logic [N-1:0]  stored_q [M];
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  out_data [M];
    logic [M-1:0]  out_flip;
    logic [CW-1:0] out_cost;

    exp_t sb_q[$];
    exp_t mon_e;
    blk_t mon_d;
    int   tests = 0;
    int   fails = 0;

    flip_encode_block #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .stored_q  (stored_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flip  (out_flip),
        .out_cost  (out_cost)
    );

    always #5 clk = ~clk;

    // Reference encoding of one block.
    function automatic exp_t model(input blk_t nw, input blk_t od);
        exp_t e;
        int   d;
        e = '0;
        for (int i = 0; i < M; i++) begin
            d = $countones(nw[i] ^ od[i]);
            if (d > N / 2) begin
                e.flip[i] = 1'b1;
                e.data[i] = ~nw[i];
                e.cost    = e.cost + CW'(N - d);
            end else begin
                e.data[i] = nw[i];
                e.cost    = e.cost + CW'(d);
            end
        end
        return e;
    endfunction

    function automatic blk_t fill(input logic [N-1:0] w);
        blk_t b;
        for (int i = 0; i < M; i++) b[i] = w;
        return b;
    endfunction

    // Scoreboard: compare every block handed downstream.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: block delivered with empty scoreboard");
            end else begin
                mon_e = sb_q.pop_front();
                for (int i = 0; i < M; i++) mon_d[i] = out_data[i];
                if (mon_d !== mon_e.data || out_flip !== mon_e.flip || out_cost !== mon_e.cost) begin
                    fails++;
                    $display("FAIL sb_block: got data=%h flip=%b cost=%0d, want data=%h flip=%b cost=%0d",
                             mon_d, out_flip, out_cost, mon_e.data, mon_e.flip, mon_e.cost);
                end
            end
        end
    end

    // Offer a block and wait for acceptance; stored_q is scrambled afterwards
    // so the encoder must be working from its own snapshot.
    task automatic send(input blk_t nw, input blk_t od, input bit push);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
        end
        in_valid = 1'b1;
        for (int i = 0; i < M; i++) begin
            in_data[i]  = nw[i];
            stored_q[i] = od[i];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < M; i++) begin
            in_data[i]  = N'($urandom);
            stored_q[i] = N'($urandom);
        end
        if (push) sb_q.push_back(model(nw, od));
    endtask

    // Count edges after acceptance until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (!out_valid) begin
            fails++;
            $display("FAIL valid_timeout: out_valid=%b want 1", out_valid);
        end
    endtask

    task automatic finish_transfer();
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL post_transfer: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_flip !== '0 || out_cost !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b flip=%b cost=%0d want 1/0/0/0",
                     in_ready, out_valid, out_flip, out_cost);
        end
        for (int i = 0; i < M; i++) begin
            tests++;
            if (out_data[i] !== 16'h0000) begin
                fails++;
                $display("FAIL reset_data[%0d]: got %h want 0000", i, out_data[i]);
            end
        end
    endtask

    task automatic test_basic_flip();
        int lat;
        send(fill(16'hFFFF), fill(16'h0000), 1'b1);
        wait_valid(lat);
        tests++;
        if (lat != M) begin
            fails++;
            $display("FAIL basic_latency: got %0d edges want %0d", lat, M);
        end
        tests++;
        if (out_flip !== 4'b1111 || out_cost !== 6'd0 || out_data[0] !== 16'h0000 || out_data[3] !== 16'h0000) begin
            fails++;
            $display("FAIL basic_flip: flip=%b cost=%0d d0=%h d3=%h want 1111/0/0000/0000",
                     out_flip, out_cost, out_data[0], out_data[3]);
        end
        finish_transfer();
    endtask

    task automatic test_tie();
        int lat;
        send(fill(16'h00FF), fill(16'h0000), 1'b1);
        wait_valid(lat);
        tests++;
        if (out_flip !== 4'b0000 || out_cost !== 6'd32 || out_data[1] !== 16'h00FF || out_data[2] !== 16'h00FF) begin
            fails++;
            $display("FAIL tie: flip=%b cost=%0d d1=%h d2=%h want 0000/32/00ff/00ff",
                     out_flip, out_cost, out_data[1], out_data[2]);
        end
        finish_transfer();
    endtask

    task automatic test_mixed();
        blk_t nw;
        int   lat;
        nw[0] = 16'h0000;
        nw[1] = 16'hFFFE;
        nw[2] = 16'h0007;
        nw[3] = 16'h0FFF;
        send(nw, fill(16'h0000), 1'b1);
        wait_valid(lat);
        tests++;
        if (out_data[0] !== 16'h0000 || out_data[1] !== 16'h0001 || out_data[2] !== 16'h0007 ||
            out_data[3] !== 16'hF000 || out_flip !== 4'b1010 || out_cost !== 6'd8) begin
            fails++;
            $display("FAIL mixed: data=%h %h %h %h flip=%b cost=%0d want 0000 0001 0007 f000 1010 8",
                     out_data[0], out_data[1], out_data[2], out_data[3], out_flip, out_cost);
        end
        finish_transfer();
    endtask

    task automatic test_backpressure();
        blk_t nw;
        blk_t od;
        exp_t e;
        blk_t got;
        int   lat;
        for (int i = 0; i < M; i++) begin
            nw[i] = N'($urandom);
            od[i] = N'($urandom);
        end
        e = model(nw, od);
        out_ready = 1'b0;
        send(nw, od, 1'b1);
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            in_valid = ~in_valid;
            for (int i = 0; i < M; i++) stored_q[i] = N'($urandom);
            for (int i = 0; i < M; i++) got[i] = out_data[i];
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== e.data || out_flip !== e.flip || out_cost !== e.cost) begin
                fails++;
                $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b data=%h flip=%b cost=%0d want 1/0/%h/%b/%0d",
                         c, out_valid, in_ready, got, out_flip, out_cost, e.data, e.flip, e.cost);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        finish_transfer();
    endtask

    task automatic test_reset_mid_scan();
        blk_t nw;
        int   lat;
        send(fill(16'h000F), fill(16'h0000), 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_flip !== '0 || out_cost !== '0) begin
            fails++;
            $display("FAIL reset_mid_scan: valid=%b ready=%b flip=%b cost=%0d want 0/1/0/0",
                     out_valid, in_ready, out_flip, out_cost);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        nw[0] = 16'h0001;
        nw[1] = 16'hFF00;
        nw[2] = 16'hFFFF;
        nw[3] = 16'h1234;
        send(nw, fill(16'h0F0F), 1'b1);
        wait_valid(lat);
        tests++;
        // 0001^0f0f=0f0e:7 ; ff00^0f0f=f00f:8 tie ; ffff^0f0f=f0f0:8 tie ; 1234^0f0f=1d3b:9 flip->7
        if (out_cost !== 6'd30 || out_flip !== 4'b1000) begin
            fails++;
            $display("FAIL reset_recover: cost=%0d flip=%b want 30/1000", out_cost, out_flip);
        end
        finish_transfer();
    endtask

    task automatic test_back_to_back();
        blk_t nw;
        blk_t od;
        int   lat;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < M; i++) begin
                nw[i] = N'($urandom);
                od[i] = (b % 2 == 0) ? ~nw[i] ^ N'(1 << (i + b)) : N'($urandom);
            end
            send(nw, od, 1'b1);
            wait_valid(lat);
            tests++;
            if (lat != M) begin
                fails++;
                $display("FAIL b2b_latency[%0d]: got %0d edges want %0d", b, lat, M);
            end
            finish_transfer();
        end
    endtask

    initial begin
        for (int i = 0; i < M; i++) begin
            in_data[i]  = '0;
            stored_q[i] = '0;
        end
        test_reset();
        test_basic_flip();
        test_tie();
        test_mixed();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d blocks never delivered", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
